hand_pos_uart_rx: RTL and testbench

- Upstream stage of the video top level. Receives hand-tracking coordinate frames from the camera/MCU over the UART pin (RX_Pin_In, gated by RX_En_Sig).
- Validates each frame and clamps it to the 640x480 screen.
- Drives the x_pos/y_pos inputs of the video top, which supply hand_x/hand_y for the fruit-ninja cursor.
- Also reports link loss and an error count.

---
 rtl/hand_pos_uart_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_hand_pos_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hand_pos_uart_rx.sv
// Hand-tracking coordinate receiver: 8N1 UART byte receiver, 7-byte frame parser,
// screen clamping, link-loss timeout and saturating error counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting half a bit, then re-checking the start bit
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling the stop bit; high gives byte_strobe, low a framing error
// P_H0     | waiting for header byte 0xAA
// P_H1     | waiting for header byte 0x55
// P_XHI    | storing X_HI
// P_XLO    | storing X_LO
// P_YHI    | storing Y_HI
// P_YLO    | storing Y_LO
// P_CHK    | comparing checksum; accept or count an error
module hand_pos_uart_rx #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       pos_valid,
    output logic       pos_lost,
    output logic [7:0] err_cnt
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int GAP_CYC = 16 * BIT_CNT;
    localparam int BIT_TW  = $clog2(BIT_CNT + 1);
    localparam int GAP_TW  = $clog2(GAP_CYC + 1);
    localparam int TMO_TW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BIT_TW-1:0] BIT_LD  = BIT_TW'(BIT_CNT - 1);
    localparam logic [BIT_TW-1:0] HALF_LD = BIT_TW'(BIT_CNT / 2 - 1);
    localparam logic [GAP_TW-1:0] GAP_LD  = GAP_TW'(GAP_CYC);
    localparam logic [TMO_TW-1:0] TMO_LD  = TMO_TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_H0, P_H1, P_XHI, P_XLO, P_YHI, P_YLO, P_CHK} p_state_t;

    rx_state_t         rx_state, rx_state_nxt;
    logic [BIT_TW-1:0] bit_tmr, bit_tmr_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [7:0]        shift_q, shift_nxt;
    logic [1:0]        rx_sync;
    logic              rx_s, rx_prev;
    logic              byte_strobe, frame_err;

    p_state_t          p_state, p_nxt;
    logic [GAP_TW-1:0] gap_tmr, gap_nxt;
    logic [7:0]        x_hi_q, x_lo_q, y_hi_q, y_lo_q;
    logic [7:0]        chk_sum;
    logic              accept, chk_err;
    logic [15:0]       raw_x, raw_y;
    logic [9:0]        x_clamp, y_clamp;
    logic [TMO_TW-1:0] tmo_tmr;

    assign rx_s = rx_sync[1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], RX_Pin_In};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_state <= RX_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            bit_tmr  <= bit_tmr_nxt;
            bit_idx  <= bit_idx_nxt;
            shift_q  <= shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        bit_tmr_nxt  = bit_tmr;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_q;
        byte_strobe  = 1'b0;
        frame_err    = 1'b0;
        if (bit_tmr != '0) bit_tmr_nxt = bit_tmr - BIT_TW'(1);
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_nxt = RX_START;
                    bit_tmr_nxt  = HALF_LD;
                end
            end
            RX_START: begin
                if (bit_tmr == '0) begin
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        bit_tmr_nxt  = BIT_LD;
                        bit_idx_nxt  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (bit_tmr == '0) begin
                    shift_nxt   = {rx_s, shift_q[7:1]};
                    bit_tmr_nxt = BIT_LD;
                    if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
                    else                 bit_idx_nxt  = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (bit_tmr == '0) begin
                    byte_strobe  = rx_s;
                    frame_err    = !rx_s;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
        // Disabling drops any partial byte silently; edge detection keeps running
        if (!RX_En_Sig) begin
            rx_state_nxt = RX_IDLE;
            byte_strobe  = 1'b0;
            frame_err    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p_state <= P_H0;
            gap_tmr <= '0;
            x_hi_q  <= '0;
            x_lo_q  <= '0;
            y_hi_q  <= '0;
            y_lo_q  <= '0;
        end else begin
            p_state <= p_nxt;
            gap_tmr <= gap_nxt;
            if (byte_strobe) begin
                if (p_state == P_XHI) x_hi_q <= shift_q;
                if (p_state == P_XLO) x_lo_q <= shift_q;
                if (p_state == P_YHI) y_hi_q <= shift_q;
                if (p_state == P_YLO) y_lo_q <= shift_q;
            end
        end
    end

    assign chk_sum = x_hi_q + x_lo_q + y_hi_q + y_lo_q;

    always_comb begin
        p_nxt   = p_state;
        gap_nxt = gap_tmr;
        accept  = 1'b0;
        chk_err = 1'b0;
        if (byte_strobe) begin
            gap_nxt = GAP_LD;
            case (p_state)
                P_H0:  if (shift_q == 8'hAA) p_nxt = P_H1;
                P_H1: begin
                    if (shift_q == 8'h55)      p_nxt = P_XHI;
                    else if (shift_q != 8'hAA) p_nxt = P_H0;
                end
                P_XHI: p_nxt = P_XLO;
                P_XLO: p_nxt = P_YHI;
                P_YHI: p_nxt = P_YLO;
                P_YLO: p_nxt = P_CHK;
                P_CHK: begin
                    p_nxt = P_H0;
                    if (shift_q == chk_sum) accept  = 1'b1;
                    else                    chk_err = 1'b1;
                end
                default: p_nxt = P_H0;
            endcase
        end else if (frame_err) begin
            p_nxt = P_H0;
        end else if (p_state != P_H0) begin
            if (gap_tmr == '0) p_nxt   = P_H0;
            else               gap_nxt = gap_tmr - GAP_TW'(1);
        end
    end

    assign raw_x   = {x_hi_q, x_lo_q};
    assign raw_y   = {y_hi_q, y_lo_q};
    assign x_clamp = (raw_x > 16'(X_MAX)) ? 10'(X_MAX) : raw_x[9:0];
    assign y_clamp = (raw_y > 16'(Y_MAX)) ? 10'(Y_MAX) : raw_y[9:0];

    // Timeout is a down-counter reloaded on accept; zero means the link is lost
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            x_pos     <= '0;
            y_pos     <= '0;
            pos_valid <= 1'b0;
            err_cnt   <= '0;
            tmo_tmr   <= '0;
        end else begin
            pos_valid <= accept;
            if (accept) begin
                x_pos   <= x_clamp;
                y_pos   <= y_clamp;
                tmo_tmr <= TMO_LD;
            end else if (tmo_tmr != '0) begin
                tmo_tmr <= tmo_tmr - TMO_TW'(1);
            end
            if ((chk_err || frame_err) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign pos_lost = (tmo_tmr == '0);

endmodule

// File: tb/tb_hand_pos_uart_rx.sv
// Bench for hand_pos_uart_rx: directed UART frames, a byte-level frame model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_hand_pos_uart_rx;

    localparam int TIMEOUT = 2000;
    localparam int GAP     = 160;

    typedef logic [7:0] bq_t[$];

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       rx_pin;
    logic       rx_en;
    logic [9:0] x_pos, y_pos;
    logic       pos_valid, pos_lost;
    logic [7:0] err_cnt;

    hand_pos_uart_rx #(
        .CLK_FREQ(50000000), .BAUD(5000000), .X_MAX(639), .Y_MAX(479), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(rx_pin), .RX_En_Sig(rx_en),
        .x_pos(x_pos), .y_pos(y_pos), .pos_valid(pos_valid), .pos_lost(pos_lost),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Byte-level model of the expected outputs
    int         mdl_st = 0;
    logic [7:0] fb[4];
    int         last_strobe = 0;
    int         exp_x = 0, exp_y = 0, exp_err = 0;
    bit         mdl_valid = 0, have_acc = 0;
    int         mdl_idle = 0;
    int         n_pulses = 0;
    bit         chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_st = 0; exp_x = 0; exp_y = 0; exp_err = 0;
        mdl_valid = 0; have_acc = 0; mdl_idle = 0;
    endtask

    task automatic model_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop);
        int raw_x, raw_y;
        logic [7:0] sum;
        if (!stop) begin
            model_err();
            mdl_st = 0;
            return;
        end
        if (mdl_st != 0 && (cyc - last_strobe) > GAP) mdl_st = 0;
        last_strobe = cyc;
        if (mdl_st == 0) begin
            if (b == 8'hAA) mdl_st = 1;
        end else if (mdl_st == 1) begin
            mdl_st = (b == 8'h55) ? 2 : ((b == 8'hAA) ? 1 : 0);
        end else if (mdl_st < 6) begin
            fb[mdl_st-2] = b;
            mdl_st++;
        end else begin
            sum = fb[0] + fb[1] + fb[2] + fb[3];
            if (b == sum) begin
                raw_x = {fb[0], fb[1]};
                raw_y = {fb[2], fb[3]};
                exp_x = (raw_x > 639) ? 639 : raw_x;
                exp_y = (raw_y > 479) ? 479 : raw_y;
                mdl_valid = 1; have_acc = 1; mdl_idle = 0;
            end else begin
                model_err();
            end
            mdl_st = 0;
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (chk_en) begin
                check("x_pos", int'(x_pos), exp_x);
                check("y_pos", int'(y_pos), exp_y);
                check("pos_valid", int'(pos_valid), int'(mdl_valid));
                check("pos_lost", int'(pos_lost), (!have_acc || mdl_idle >= TIMEOUT) ? 1 : 0);
                check("err_cnt", int'(err_cnt), exp_err);
                if (pos_valid) n_pulses++;
                mdl_valid = 0;
                if (mdl_idle < TIMEOUT) mdl_idle++;
            end
        end
    end

    // One 8N1 byte, 10 clocks per bit; model is told of it on the cycle outputs change
    task automatic send_byte(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge CLK);
        for (int k = 0; k < 10; k++) begin
            #1 rx_pin = fr[k];
            if (k == 9) begin
                repeat (8) @(posedge CLK);
                model_byte(b, stop);
                repeat (2) @(posedge CLK);
            end else begin
                repeat (10) @(posedge CLK);
            end
        end
        #1 rx_pin = 1'b1;
    endtask

    task automatic send_q(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic check_outs(input string tag, input int x, input int y, input int lost,
                              input int err, input int pulses);
        check({tag, ".x"}, int'(x_pos), x);
        check({tag, ".y"}, int'(y_pos), y);
        check({tag, ".lost"}, int'(pos_lost), lost);
        check({tag, ".err"}, int'(err_cnt), err);
        check({tag, ".pulses"}, n_pulses, pulses);
    endtask

    bq_t fq;

    initial begin
        RSTn = 1'b0; rx_pin = 1'b1; rx_en = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check_outs("reset", 0, 0, 1, 0, 0);
        check("reset.valid", int'(pos_valid), 0);
        RSTn = 1'b1;
        chk_en = 1;
        idle(20);

        fq = '{8'hAA, 8'h55, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'h1D};
        send_q(fq);
        idle(5);
        check_outs("good", 300, 240, 0, 0, 1);

        fq = '{8'hAA, 8'h55, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'h1E};
        send_q(fq);
        idle(5);
        check_outs("badchk", 300, 240, 0, 1, 1);

        fq = '{8'hAA, 8'h55, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE0};
        send_q(fq);
        idle(5);
        check_outs("clamp", 639, 479, 0, 1, 2);

        fq = '{8'hAA, 8'hAA, 8'h55, 8'h00, 8'h64, 8'h00, 8'h32, 8'h96};
        send_q(fq);
        idle(5);
        check_outs("resync", 100, 50, 0, 1, 3);

        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h2C, 1'b0);
        idle(10);
        check_outs("framing", 100, 50, 0, 2, 3);
        fq = '{8'hAA, 8'h55, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'h1D};
        send_q(fq);
        idle(2);
        check_outs("after_framing", 300, 240, 0, 2, 4);

        idle(TIMEOUT);
        check_outs("timeout", 300, 240, 1, 2, 4);

        // Partial byte with the receiver disabled in the middle; it must vanish
        send_byte(8'hAA, 1'b1);
        @(posedge CLK);
        #1 rx_pin = 1'b0;
        repeat (10) @(posedge CLK);
        #1 rx_en = 1'b0;
        repeat (30) @(posedge CLK);
        #1 rx_en = 1'b1; rx_pin = 1'b1;
        fq = '{8'h55, 8'h00, 8'h64, 8'h00, 8'h32, 8'h96};
        send_q(fq);
        idle(5);
        check_outs("enable", 100, 50, 0, 2, 5);

        fq = '{8'hAA, 8'h55, 8'h01};
        send_q(fq);
        idle(200);
        fq = '{8'h2C, 8'h00, 8'hF0, 8'h1D};
        send_q(fq);
        idle(5);
        check_outs("gap", 100, 50, 0, 2, 5);
        fq = '{8'hAA, 8'h55, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE0};
        send_q(fq);
        idle(5);
        check_outs("after_gap", 639, 479, 0, 2, 6);

        // Asynchronous reset in the middle of X_LO
        fq = '{8'hAA, 8'h55, 8'h01};
        send_q(fq);
        @(posedge CLK);
        #1 rx_pin = 1'b0;
        repeat (25) @(posedge CLK);
        #3;
        chk_en = 0;
        RSTn = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 1, 0, 6);
        check("async_rst.valid", int'(pos_valid), 0);
        model_reset();
        rx_pin = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RSTn = 1'b1;
        chk_en = 1;
        idle(30);
        fq = '{8'hAA, 8'h55, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'h1D};
        send_q(fq);
        idle(5);
        check_outs("after_rst", 300, 240, 0, 0, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
